mem_arbiter: RTL and testbench
==============================

Name: mem_arbiter

Overview:
- Arbitrates a single-port unified memory between two requesters: the IF-stage instruction fetch port and the MEM-stage data port of the 16-bit pipelined CPU.
- Sequences each access through a fixed number of memory wait states.
- Returns read data in a registered form and raises a pipeline stall while any request is outstanding.
- Sits between the pipeline (pc/buffer logic) and the memory array, replacing separate instruction and data memories.

Parameters:
- ADDR_W, 16, address width
- DATA_W, 16, data width
- WAIT, 2, memory access cycles per transaction (>=1)

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with if_addr stable until if_ready
- if_addr  in  ADDR_W  fetch address
- if_ready  out  1  one-cycle pulse: fetch complete
- if_rdata  out  DATA_W  registered fetch data
- d_req  in  1  data request; held with d_we, d_byte, d_addr, d_wdata stable until d_ready
- d_we  in  1  1 = write, 0 = read
- d_byte  in  2  byte-access code, passed through to memory
- d_addr  in  ADDR_W  data address
- d_wdata  in  DATA_W  write data
- d_ready  out  1  one-cycle pulse: data access complete
- d_rdata  out  DATA_W  registered read data
- mem_en  out  1  memory enable
- mem_we  out  1  memory write enable
- mem_byte  out  2  byte-access code to memory
- mem_addr  out  ADDR_W  memory address
- mem_wdata  out  DATA_W  memory write data
- mem_rdata  in  DATA_W  memory read data; valid in the last ACCESS cycle
- stall  out  1  (if_req & ~if_ready) | (d_req & ~d_ready); combinational

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, owner=IF, last_owner=IF, cnt=0, all mem_* outputs 0, if_ready=d_ready=0, if_rdata=d_rdata=0. Takes effect mid-transaction; mem_en drops immediately; the aborted access produces no ready.
- State IDLE:
  - mem_en=0.
  - Only d_req: grant D.
  - Only if_req: grant IF.
  - Both requesting: grant the requester that is not last_owner. After reset, D wins first, so the two requesters alternate under contention.
  - On a grant: latch address, we, byte and wdata (fetch uses we=0, byte=0); owner<=grantee; cnt<=WAIT-1; go to ACCESS.
- State ACCESS:
  - mem_en=1; mem_* driven from the latched fields.
  - mem_we=1 only when owner=D and latched we=1.
  - Each cycle: cnt<=cnt-1.
  - When cnt==0: capture mem_rdata into the owner's rdata register (reads only; writes leave rdata unchanged); last_owner<=owner; go to RESP.
- State RESP:
  - mem_en=0; assert ready for the owner only; go to IDLE.
  - The requester must drop req in the next cycle. If req is still high in that IDLE cycle, it is a new request.
- Latency: request seen in IDLE at cycle 0 -> ready in cycle WAIT+1. Back-to-back turnaround is WAIT+2 cycles per access.
- Request inputs are ignored outside IDLE, so a request that changes during ACCESS has no effect.
- rdata registers hold their value until the next read by the same owner.
- stall: high in every cycle a req is high and its ready is not. It is low in the RESP cycle unless the other requester is waiting.
- WAIT=1: ACCESS lasts exactly one cycle.

Test Plan:
- Reset: drive rst=0 mid-ACCESS (WAIT=2) -> all outputs 0 in the same cycle; state is IDLE after release; no ready pulse follows.
- Single fetch:
  - stimulus: if_req=1, if_addr=0x0010, memory returns 0x1234, WAIT=2.
  - response: mem_en=1, mem_addr=0x0010 in cycles 1-2; if_ready=1 and if_rdata=0x1234 in cycle 3; stall=1 in cycles 0-2, 0 in cycle 3.
- Data write:
  - stimulus: d_req=1, d_we=1, d_byte=2'b01, d_addr=0x0042, d_wdata=0x00AB.
  - response: mem_we=1, mem_byte=01 in cycles 1-2 only; d_ready in cycle 3; d_rdata unchanged.
- Contention: if_req and d_req both high from cycle 0 -> D granted first (d_ready in cycle 3); IF granted in cycle 4 (if_ready in cycle 7); stall=1 throughout cycles 0-6.
- Fairness: both requesters re-request continuously for 6 transactions -> grant order D, IF, D, IF, D, IF.
- WAIT=1 read: d_req with d_addr=0x0100, memory returns 0xBEEF -> d_ready and d_rdata=0xBEEF in cycle 2; mem_en high only in cycle 1.

Source files
------------

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (IF) and data (D) requesters.
// Each access occupies WAIT memory cycles followed by a one-cycle ready response.
module mem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int DATA_W = 16,
  parameter int WAIT   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ready,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_byte,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_ready,
  output logic [DATA_W-1:0] d_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [1:0]        mem_byte,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              stall
);
  localparam int CNT_W = (WAIT > 1) ? $clog2(WAIT) : 1;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t            r_state;
  logic              r_owner_d;
  logic              r_last_d;
  logic              r_we;
  logic [1:0]        r_byte;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_if_ready;
  logic              r_d_ready;
  logic [DATA_W-1:0] r_if_rdata;
  logic [DATA_W-1:0] r_d_rdata;
  logic              w_grant_d;

  // Under contention the side that did not own the previous access wins.
  assign w_grant_d = d_req & (~if_req | ~r_last_d);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_owner_d  <= 1'b0;
      r_last_d   <= 1'b0;
      r_we       <= 1'b0;
      r_byte     <= '0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_cnt      <= '0;
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      r_if_rdata <= '0;
      r_d_rdata  <= '0;
    end else begin
      r_if_ready <= 1'b0;
      r_d_ready  <= 1'b0;
      case (r_state)
        IDLE: begin
          if (if_req | d_req) begin
            r_owner_d <= w_grant_d;
            r_addr    <= w_grant_d ? d_addr : if_addr;
            r_we      <= w_grant_d & d_we;
            r_byte    <= w_grant_d ? d_byte : 2'b00;
            r_wdata   <= w_grant_d ? d_wdata : '0;
            r_cnt     <= CNT_W'(WAIT - 1);
            r_state   <= ACCESS;
          end
        end
        ACCESS: begin
          r_cnt <= r_cnt - CNT_W'(1);
          if (r_cnt == '0) begin
            if (!r_we) begin
              if (r_owner_d) r_d_rdata  <= mem_rdata;
              else           r_if_rdata <= mem_rdata;
            end
            r_last_d   <= r_owner_d;
            r_if_ready <= ~r_owner_d;
            r_d_ready  <= r_owner_d;
            r_state    <= RESP;
          end
        end
        RESP:    r_state <= IDLE;
        default: r_state <= IDLE;
      endcase
    end
  end

  assign mem_en    = (r_state == ACCESS);
  assign mem_we    = mem_en & r_owner_d & r_we;
  assign mem_byte  = r_byte;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;

  assign if_ready  = r_if_ready;
  assign d_ready   = r_d_ready;
  assign if_rdata  = r_if_rdata;
  assign d_rdata   = r_d_rdata;

  assign stall = (if_req & ~if_ready) | (d_req & ~d_ready);
endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed cycle expectations plus randomized traffic,
// all checked by one monitor against queued expectations and a memory model.
module tb_mem_arbiter;
  localparam int AW = 16, DW = 16, WT = 2;

  logic clk = 1'b0;
  logic rst;
  logic          if_req, if_ready, d_req, d_we, d_ready, mem_en, mem_we, stall;
  logic [AW-1:0] if_addr, d_addr, mem_addr;
  logic [DW-1:0] if_rdata, d_wdata, d_rdata, mem_wdata, mem_rdata;
  logic [1:0]    d_byte, mem_byte;
  logic          if_req1, if_ready1, d_req1, d_we1, d_ready1, mem_en1, mem_we1, stall1;
  logic [AW-1:0] if_addr1, d_addr1, mem_addr1;
  logic [DW-1:0] if_rdata1, d_wdata1, d_rdata1, mem_wdata1, mem_rdata1;
  logic [1:0]    d_byte1, mem_byte1;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT(WT)) u_dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ready(if_ready), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_byte(d_byte), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_ready(d_ready), .d_rdata(d_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_byte(mem_byte), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .stall(stall));

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WAIT(1)) u_dut1 (
    .clk(clk), .rst(rst),
    .if_req(if_req1), .if_addr(if_addr1), .if_ready(if_ready1), .if_rdata(if_rdata1),
    .d_req(d_req1), .d_we(d_we1), .d_byte(d_byte1), .d_addr(d_addr1), .d_wdata(d_wdata1),
    .d_ready(d_ready1), .d_rdata(d_rdata1),
    .mem_en(mem_en1), .mem_we(mem_we1), .mem_byte(mem_byte1), .mem_addr(mem_addr1),
    .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .stall(stall1));

  // Memory contents as a pure function of address.
  function automatic logic [DW-1:0] mf(logic [AW-1:0] a);
    if (a == 16'h0010) return 16'h1234;
    if (a == 16'h0100) return 16'hBEEF;
    return (a * 16'h9E37) ^ 16'h5A5A;
  endfunction

  // Data is only correct in the last access cycle; earlier cycles return its complement.
  int acnt;
  always @(posedge clk) acnt <= mem_en ? acnt + 1 : 0;
  assign mem_rdata  = (mem_en && acnt == WT - 1) ? mf(mem_addr) : ~mf(mem_addr);
  assign mem_rdata1 = mem_en1 ? mf(mem_addr1) : 16'hDEAD;

  typedef enum int {S_EN, S_WE, S_BYTE, S_ADDR, S_STALL, S_IFRDY, S_DRDY, S_IFRD, S_DRD,
                    S_EN1, S_DRDY1, S_DRD1, S_CTL1, S_DAT1, S_TO, S_QIF, S_QD} sig_e;
  typedef struct { int cyc; sig_e s; logic [31:0] v; string nm; } exp_t;

  exp_t          eq[$];
  logic [DW-1:0] exp_if[$], exp_d[$];
  logic [DW-1:0] d_last;
  int            cyc, checks, errors;
  bit            to_if, to_d;

  function automatic logic [31:0] sig(sig_e s);
    case (s)
      S_EN:    return 32'(mem_en);
      S_WE:    return 32'(mem_we);
      S_BYTE:  return 32'(mem_byte);
      S_ADDR:  return 32'(mem_addr);
      S_STALL: return 32'(stall);
      S_IFRDY: return 32'(if_ready);
      S_DRDY:  return 32'(d_ready);
      S_IFRD:  return 32'(if_rdata);
      S_DRD:   return 32'(d_rdata);
      S_EN1:   return 32'(mem_en1);
      S_DRDY1: return 32'(d_ready1);
      S_DRD1:  return 32'(d_rdata1);
      S_CTL1:  return 32'({if_ready1, mem_we1, mem_byte1, stall1});
      S_DAT1:  return {if_rdata1, mem_wdata1};
      S_TO:    return 32'({to_if, to_d});
      S_QIF:   return 32'(exp_if.size());
      default: return 32'(exp_d.size());
    endcase
  endfunction

  function automatic bit bus_ok();
    return (if_req && mem_addr == if_addr && !mem_we && mem_byte == 2'b00) ||
           (d_req && mem_addr == d_addr && mem_byte == d_byte && mem_we == d_we &&
            (!d_we || mem_wdata == d_wdata));
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  // Monitor: cycle-indexed expectations, ready-triggered rdata scoreboard, bus legality.
  always @(negedge clk) begin
    for (int i = eq.size() - 1; i >= 0; i--)
      if (eq[i].cyc == cyc) begin
        chk(eq[i].nm, sig(eq[i].s), eq[i].v);
        eq.delete(i);
      end
    if (if_ready) begin
      chk("if_ready_expected", 32'(exp_if.size() != 0), 32'd1);
      if (exp_if.size() != 0) chk("if_rdata", 32'(if_rdata), 32'(exp_if.pop_front()));
    end
    if (d_ready) begin
      chk("d_ready_expected", 32'(exp_d.size() != 0), 32'd1);
      if (exp_d.size() != 0) chk("d_rdata", 32'(d_rdata), 32'(exp_d.pop_front()));
    end
    if (mem_en) chk("mem_bus", 32'(bus_ok()), 32'd1);
    cyc++;
  end

  task automatic ex(int c, sig_e s, logic [31:0] v, string nm);
    exp_t e;
    e.cyc = c; e.s = s; e.v = v; e.nm = nm;
    eq.push_back(e);
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  // Each txn leaves req high on return; the caller drops it or issues another.
  task automatic if_txn(logic [AW-1:0] a);
    int n;
    if_req = 1'b1; if_addr = a;
    exp_if.push_back(mf(a));
    for (n = 0; n < 64; n++) begin @(negedge clk); if (if_ready) break; end
    if (n == 64) begin to_if = 1'b1; ex(cyc + 2, S_TO, 0, "if_timeout"); end
    step();
  endtask

  task automatic d_txn(logic we, logic [1:0] byt, logic [AW-1:0] a, logic [DW-1:0] wd);
    int n;
    d_req = 1'b1; d_we = we; d_byte = byt; d_addr = a; d_wdata = wd;
    if (!we) d_last = mf(a);
    exp_d.push_back(d_last);
    for (n = 0; n < 64; n++) begin @(negedge clk); if (d_ready) break; end
    if (n == 64) begin to_d = 1'b1; ex(cyc + 2, S_TO, 0, "d_timeout"); end
    step();
  endtask

  initial begin
    int base;
    rst = 1'b0; to_if = 1'b0; to_d = 1'b0; d_last = '0;
    if_req = 0; if_addr = '0; d_req = 0; d_we = 0; d_byte = '0; d_addr = '0; d_wdata = '0;
    if_req1 = 0; if_addr1 = '0; d_req1 = 0; d_we1 = 0; d_byte1 = '0; d_addr1 = '0; d_wdata1 = '0;
    ex(0, S_EN, 0, "reset_mem_en");     ex(0, S_WE, 0, "reset_mem_we");
    ex(0, S_ADDR, 0, "reset_mem_addr"); ex(0, S_BYTE, 0, "reset_mem_byte");
    ex(0, S_IFRDY, 0, "reset_if_ready"); ex(0, S_DRDY, 0, "reset_d_ready");
    ex(0, S_IFRD, 0, "reset_if_rdata"); ex(0, S_DRD, 0, "reset_d_rdata");
    step(); step();
    rst = 1'b1;
    step();

    // Single fetch
    base = cyc;
    for (int c = 0; c < 4; c++) begin
      ex(base + c, S_EN, 32'(c == 1 || c == 2), "fetch_mem_en");
      ex(base + c, S_STALL, 32'(c < 3), "fetch_stall");
      ex(base + c, S_IFRDY, 32'(c == 3), "fetch_if_ready");
    end
    ex(base + 1, S_ADDR, 32'h0010, "fetch_mem_addr");
    ex(base + 2, S_ADDR, 32'h0010, "fetch_mem_addr");
    ex(base + 3, S_IFRD, 32'h1234, "fetch_if_rdata");
    if_txn(16'h0010);
    if_req = 1'b0;

    // Data read, then a write that must leave d_rdata holding the read value
    d_txn(1'b0, 2'b00, 16'h0100, 16'h0000);
    d_req = 1'b0;
    step();
    base = cyc;
    for (int c = 0; c < 4; c++) begin
      ex(base + c, S_WE, 32'(c == 1 || c == 2), "write_mem_we");
      ex(base + c, S_DRDY, 32'(c == 3), "write_d_ready");
    end
    ex(base + 1, S_BYTE, 32'h1, "write_mem_byte");
    ex(base + 2, S_BYTE, 32'h1, "write_mem_byte");
    ex(base + 3, S_DRD, 32'hBEEF, "write_d_rdata_held");
    d_txn(1'b1, 2'b01, 16'h0042, 16'h00AB);
    d_req = 1'b0;
    step();

    // Reset asserted in the middle of an access
    base = cyc;
    if_req = 1'b1; if_addr = 16'h0077;
    step();
    rst = 1'b0; d_last = '0;
    ex(base + 1, S_EN, 0, "midrst_mem_en");   ex(base + 1, S_ADDR, 0, "midrst_mem_addr");
    ex(base + 1, S_IFRD, 0, "midrst_if_rdata"); ex(base + 1, S_DRD, 0, "midrst_d_rdata");
    for (int c = 1; c < 5; c++) ex(base + c, S_IFRDY, 0, "midrst_no_ready");
    if_req = 1'b0;
    step();
    rst = 1'b1;
    repeat (3) step();

    // Contention and fairness: both requesters back to back for three accesses each
    base = cyc;
    for (int c = 0; c < 7; c++) ex(base + c, S_STALL, 1, "contend_stall");
    ex(base + 23, S_STALL, 0, "contend_stall_end");
    ex(base + 1, S_ADDR, 32'h0300, "contend_first_d");
    ex(base + 4, S_EN, 0, "contend_gap");
    ex(base + 5, S_EN, 1, "contend_if_en");
    ex(base + 5, S_ADDR, 32'h0200, "contend_if_addr");
    ex(base + 3, S_IFRDY, 0, "contend_if_not_first");
    ex(base + 7, S_DRDY, 0, "contend_d_not_second");
    for (int k = 0; k < 3; k++) begin
      ex(base + 3 + 8 * k, S_DRDY, 1, "fair_d_ready");
      ex(base + 7 + 8 * k, S_IFRDY, 1, "fair_if_ready");
    end
    fork
      begin for (int k = 0; k < 3; k++) if_txn(16'h0200 + 16'(k)); if_req = 1'b0; end
      begin for (int k = 0; k < 3; k++) d_txn(1'b0, 2'b00, 16'h0300 + 16'(k), 16'h0); d_req = 1'b0; end
    join
    step();

    // WAIT=1 instance
    base = cyc;
    d_req1 = 1'b1; d_addr1 = 16'h0100;
    ex(base, S_EN1, 0, "w1_mem_en");     ex(base + 1, S_EN1, 1, "w1_mem_en");
    ex(base + 2, S_EN1, 0, "w1_mem_en");  ex(base + 1, S_DRDY1, 0, "w1_d_ready");
    ex(base + 2, S_DRDY1, 1, "w1_d_ready"); ex(base + 2, S_DRD1, 32'hBEEF, "w1_d_rdata");
    ex(base + 1, S_CTL1, 1, "w1_ctl");    ex(base + 2, S_CTL1, 0, "w1_ctl");
    ex(base + 2, S_DAT1, 0, "w1_dat");
    step(); step(); step();
    d_req1 = 1'b0;
    step();

    // Randomized traffic from both sides
    fork
      for (int k = 0; k < 30; k++) begin
        int g;
        g = $urandom_range(0, 3);
        if (g != 0) begin if_req = 1'b0; repeat (g) step(); end
        if_txn(16'($urandom));
      end
      for (int k = 0; k < 30; k++) begin
        int g;
        g = $urandom_range(0, 3);
        if (g != 0) begin d_req = 1'b0; repeat (g) step(); end
        d_txn(1'($urandom), 2'($urandom), 16'($urandom), 16'($urandom));
      end
    join
    if_req = 1'b0; d_req = 1'b0;

    repeat (4) step();
    ex(cyc, S_QIF, 0, "if_queue_drained");
    ex(cyc, S_QD, 0, "d_queue_drained");
    ex(cyc, S_TO, 0, "no_timeout");
    repeat (3) step();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
